stack_drain_seq: RTL and testbench

STACK_DRAIN_SEQ -- requirements
Module: stack_drain_seq

---
 rtl/stack_drain_seq.sv | 129 ++++++++++++
 tb/tb_stack_drain_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_drain_seq.sv
// Pops a hardware stack one entry at a time and shows each popped value on the LEDs
// for a fixed hold time. It can drain the whole stack or pop a single entry.
module stack_drain_seq #(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 4,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step,
    input  logic                  abort,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  pop,
    output logic [DATA_WIDTH-1:0] led,
    output logic                  led_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   popped_count
);

    localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(1 << ADDR_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [HW-1:0]         hold_cnt;
    logic [HW-1:0]         hold_n;
    logic                  single_step;
    logic                  single_n;
    logic [DATA_WIDTH-1:0] led_n;
    logic                  led_valid_n;
    logic [CW-1:0]         count_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            single_step  <= 1'b0;
            led          <= '0;
            led_valid    <= 1'b0;
            popped_count <= '0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            single_step  <= single_n;
            led          <= led_n;
            led_valid    <= led_valid_n;
            popped_count <= count_n;
        end
    end

    // abort overrides everything else; the displayed value and count survive it
    always_comb begin
        state_n     = state;
        hold_n      = hold_cnt;
        single_n    = single_step;
        led_n       = led;
        led_valid_n = led_valid;
        count_n     = popped_count;
        pop         = 1'b0;
        done        = 1'b0;
        if (abort) begin
            state_n = IDLE;
            hold_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count_n     = '0;
                        led_valid_n = 1'b0;
                        single_n    = 1'b0;
                        state_n     = empty ? DONE : POP;
                    end else if (step && !empty) begin
                        count_n     = '0;
                        led_valid_n = 1'b0;
                        single_n    = 1'b1;
                        state_n     = POP;
                    end
                end
                POP: begin
                    pop         = 1'b1;
                    led_n       = r_data;
                    led_valid_n = 1'b1;
                    if (popped_count != CNT_MAX) begin
                        count_n = popped_count + 1'b1;
                    end
                    hold_n  = '0;
                    state_n = HOLD;
                end
                HOLD: begin
                    // empty is only trusted here, long after the pop has settled
                    if (hold_cnt == HOLD_LAST) begin
                        hold_n = '0;
                        if (single_step) begin
                            state_n = IDLE;
                        end else if (empty) begin
                            state_n = DONE;
                        end else begin
                            state_n = POP;
                        end
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_stack_drain_seq.sv
// Directed bench for stack_drain_seq with a small behavioural stack whose empty
// flag follows a pop one cycle later.
module tb_stack_drain_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       step;
    logic       abort;
    logic       empty;
    logic [3:0] r_data;
    logic       pop;
    logic [3:0] led;
    logic       led_valid;
    logic       busy;
    logic       done;
    logic [4:0] popped_count;

    int total = 0;
    int bad   = 0;

    logic [3:0] stk [0:31];
    int         loaded = 0;
    int         base = 0;
    int         pop_total = 0;
    int         depth;
    logic [4:0] top_idx;

    stack_drain_seq #(
        .DATA_WIDTH (4),
        .ADDR_WIDTH (4),
        .HOLD_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .step        (step),
        .abort       (abort),
        .empty       (empty),
        .r_data      (r_data),
        .pop         (pop),
        .led         (led),
        .led_valid   (led_valid),
        .busy        (busy),
        .done        (done),
        .popped_count(popped_count)
    );

    always #5 clk = ~clk;

    // stack model: depth falls on the edge that sees pop, so empty lags a pop by a cycle
    always @(posedge clk) begin
        if (pop) pop_total <= pop_total + 1;
    end

    assign depth   = loaded - (pop_total - base);
    assign empty   = (depth <= 0);
    assign top_idx = 5'(depth - 1);
    assign r_data  = (depth > 0) ? stk[top_idx] : 4'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_depth(input int n);
        loaded = n;
        base   = pop_total;
    endtask

    task automatic apply_stimulus(input logic s, input logic st, input logic a);
        start = s;
        step  = st;
        abort = a;
        tick();
        start = 1'b0;
        step  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int pops_before;
        int n;

        reset = 1'b1;
        start = 1'b0;
        step  = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_output("rst_pop", 32'(pop), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        check_output("rst_led", 32'(led), 32'h0);
        check_output("rst_valid", 32'(led_valid), 32'h0);
        check_output("rst_count", 32'(popped_count), 32'h0);

        $display("[TB] drain of 3,7,9");
        stk[0] = 4'h3; stk[1] = 4'h7; stk[2] = 4'h9;
        set_depth(3);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            check_output("drain3_pop", 32'(pop), 32'((c == 1 || c == 6 || c == 11) ? 1 : 0));
            check_output("drain3_done", 32'(done), 32'((c == 16) ? 1 : 0));
            check_output("drain3_busy", 32'(busy), 32'h1);
            if (c == 2)  check_output("drain3_led1", 32'(led), 32'h9);
            if (c == 7)  check_output("drain3_led2", 32'(led), 32'h7);
            if (c == 12) check_output("drain3_led3", 32'(led), 32'h3);
            tick();
        end
        check_output("drain3_idle", 32'(busy), 32'h0);
        check_output("drain3_count", 32'(popped_count), 32'h3);
        check_output("drain3_valid", 32'(led_valid), 32'h1);

        $display("[TB] start on empty stack");
        set_depth(0);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("empty_done", 32'(done), 32'h1);
        check_output("empty_pop", 32'(pop), 32'h0);
        check_output("empty_busy", 32'(busy), 32'h1);
        tick();
        check_output("empty_idle", 32'(busy), 32'h0);
        check_output("empty_done_low", 32'(done), 32'h0);
        check_output("empty_count", 32'(popped_count), 32'h0);
        check_output("empty_valid", 32'(led_valid), 32'h0);
        check_output("empty_led_kept", 32'(led), 32'h3);
        pops_before = pop_total;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("empty_step_busy", 32'(busy), 32'h0);
        check_output("empty_step_pops", 32'(pop_total - pops_before), 32'h0);

        $display("[TB] single step on 5,A");
        stk[0] = 4'h5; stk[1] = 4'hA;
        set_depth(2);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            check_output("step_pop", 32'(pop), 32'((c == 1) ? 1 : 0));
            check_output("step_busy", 32'(busy), 32'h1);
            check_output("step_done", 32'(done), 32'h0);
            tick();
        end
        check_output("step_idle", 32'(busy), 32'h0);
        check_output("step_no_done", 32'(done), 32'h0);
        check_output("step_led", 32'(led), 32'hA);
        check_output("step_count", 32'(popped_count), 32'h1);

        $display("[TB] abort mid-hold");
        stk[0] = 4'h1; stk[1] = 4'h2;
        set_depth(2);
        pops_before = pop_total;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        check_output("abort_first_pop", 32'(pop), 32'h1);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("abort_idle", 32'(busy), 32'h0);
        for (int c = 0; c < 10; c++) begin
            check_output("abort_no_pop", 32'(pop), 32'h0);
            check_output("abort_no_done", 32'(done), 32'h0);
            tick();
        end
        check_output("abort_pops", 32'(pop_total - pops_before), 32'h1);
        check_output("abort_led", 32'(led), 32'h2);
        check_output("abort_count", 32'(popped_count), 32'h1);
        check_output("abort_valid", 32'(led_valid), 32'h1);
        apply_stimulus(1'b1, 1'b0, 1'b1);
        check_output("abort_beats_start", 32'(busy), 32'h0);
        check_output("abort_beats_count", 32'(popped_count), 32'h1);

        $display("[TB] reset in second hold cycle");
        stk[0] = 4'h4; stk[1] = 4'h6;
        set_depth(2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("midrst_busy", 32'(busy), 32'h0);
        check_output("midrst_pop", 32'(pop), 32'h0);
        check_output("midrst_done", 32'(done), 32'h0);
        check_output("midrst_led", 32'(led), 32'h0);
        check_output("midrst_valid", 32'(led_valid), 32'h0);
        check_output("midrst_count", 32'(popped_count), 32'h0);
        set_depth(2);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            check_output("postrst_pop", 32'(pop), 32'((c == 1 || c == 6) ? 1 : 0));
            check_output("postrst_done", 32'(done), 32'((c == 11) ? 1 : 0));
            tick();
        end
        check_output("postrst_led", 32'(led), 32'h4);
        check_output("postrst_count", 32'(popped_count), 32'h2);

        $display("[TB] start+step together, start while busy");
        stk[0] = 4'h8; stk[1] = 4'hB;
        set_depth(2);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            check_output("both_pop", 32'(pop), 32'((c == 1 || c == 6) ? 1 : 0));
            check_output("both_done", 32'(done), 32'((c == 11) ? 1 : 0));
            start = (c == 3);
            tick();
        end
        start = 1'b0;
        check_output("both_idle", 32'(busy), 32'h0);
        check_output("both_led", 32'(led), 32'h8);
        check_output("both_count", 32'(popped_count), 32'h2);

        $display("[TB] popped_count saturation");
        for (int i = 0; i < 17; i++) stk[i] = 4'(i);
        set_depth(17);
        apply_stimulus(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check_output("sat_done", 32'(done), 32'h1);
        check_output("sat_count", 32'(popped_count), 32'h10);
        check_output("sat_led", 32'(led), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
